// File: rtl/gs_host_master.sv
// Host-side initiator for the General Sound mailbox ports #B3/#BB: turns single-beat
// commands into Z80-style I/O bus cycles, optionally polling GS status first.
module gs_host_master #(
  parameter int          T_SETUP  = 2,
  parameter int          T_STROBE = 6,
  parameter int          T_HOLD   = 2,
  parameter int          POLL_MAX = 4096,
  parameter logic [7:0]  ADDR_HI  = 8'h00
) (
  input  logic        clk32,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_poll,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        n_iorq,
  output logic        n_rd,
  output logic        n_wr,
  output logic        n_m1
);

  localparam int T_MAX = (T_SETUP > T_STROBE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                              : ((T_STROBE > T_HOLD) ? T_STROBE : T_HOLD);
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam int PW    = $clog2(POLL_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_P_SETUP,
    S_P_STROBE,
    S_P_HOLD,
    S_P_CHECK,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt;
  logic [PW-1:0]     poll_cnt;
  logic [1:0]        op_q;
  logic [1:0]        op_eff;
  logic [7:0]        st_q;
  logic [7:0]        rdata_q;
  logic              timeout_q;
  logic [15:0]       a_q;
  logic [7:0]        d_out_q;
  logic              poll_met;
  logic              poll_last;
  logic              cnt_zero;
  logic              is_write;

  // Each timed phase loads its length minus one and advances when the counter hits zero.
  function automatic logic [CNT_W-1:0] dur(input state_t s);
    case (s)
      S_P_SETUP,  S_SETUP:  dur = CNT_W'(T_SETUP - 1);
      S_P_STROBE, S_STROBE: dur = CNT_W'(T_STROBE - 1);
      S_P_HOLD,   S_HOLD:   dur = CNT_W'(T_HOLD - 1);
      default:              dur = '0;
    endcase
  endfunction

  assign cnt_zero  = (cnt == '0);
  assign is_write  = ~op_q[1];
  assign op_eff    = (state == S_IDLE) ? cmd_op : op_q;
  assign poll_last = (poll_cnt == PW'(POLL_MAX - 1));

  always_comb begin
    poll_met = 1'b1;
    case (op_q)
      2'd0:    poll_met = ~st_q[7];
      2'd1:    poll_met = ~st_q[0];
      2'd2:    poll_met =  st_q[7];
      default: poll_met = 1'b1;
    endcase
  end

  // NOTE: every combinational output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:     if (cmd_valid) state_d = (cmd_poll && cmd_op != 2'd3) ? S_P_SETUP : S_SETUP;
      S_P_SETUP:  if (cnt_zero) state_d = S_P_STROBE;
      S_P_STROBE: if (cnt_zero) state_d = S_P_HOLD;
      S_P_HOLD:   if (cnt_zero) state_d = S_P_CHECK;
      S_P_CHECK: begin
        if (poll_met)       state_d = S_SETUP;
        else if (poll_last) state_d = S_DONE;
        else                state_d = S_P_SETUP;
      end
      S_SETUP:    if (cnt_zero) state_d = S_STROBE;
      S_STROBE:   if (cnt_zero) state_d = S_HOLD;
      S_HOLD:     if (cnt_zero) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      poll_cnt  <= '0;
      op_q      <= 2'd0;
      st_q      <= 8'h00;
      rdata_q   <= 8'h00;
      timeout_q <= 1'b0;
      a_q       <= 16'h0000;
      d_out_q   <= 8'h00;
    end else begin
      state <= state_d;

      if (state_d != state) cnt <= dur(state_d);
      else if (!cnt_zero)   cnt <= cnt - CNT_W'(1);

      if (state == S_IDLE && cmd_valid) begin
        op_q      <= cmd_op;
        poll_cnt  <= '0;
        timeout_q <= 1'b0;
        if (!cmd_op[1]) d_out_q <= cmd_wdata;
      end

      // Address is latched on entry to a bus cycle and held until the next one starts.
      if (state_d == S_P_SETUP && state != S_P_SETUP)
        a_q <= {ADDR_HI, 8'hBB};
      else if (state_d == S_SETUP && state != S_SETUP)
        a_q <= {ADDR_HI, op_eff[0] ? 8'hBB : 8'hB3};

      if (state == S_P_STROBE && cnt_zero) st_q <= d_in;
      if (state == S_STROBE && cnt_zero && op_q[1]) rdata_q <= d_in;

      if (state == S_P_CHECK && !poll_met) begin
        if (poll_last) begin
          timeout_q <= 1'b1;
          rdata_q   <= st_q;
        end else begin
          poll_cnt <= poll_cnt + PW'(1);
        end
      end
    end
  end

  // Strobes decode straight from the state register so reset releases them asynchronously.
  assign cmd_ready   = (state == S_IDLE);
  assign rsp_valid   = (state == S_DONE);
  assign rsp_timeout = (state == S_DONE) && timeout_q;
  assign rsp_rdata   = rdata_q;
  assign a           = a_q;
  assign d_out       = d_out_q;
  assign d_oe        = is_write && (state == S_SETUP || state == S_STROBE || state == S_HOLD);
  assign n_iorq      = ~(state == S_STROBE || state == S_P_STROBE);
  assign n_rd        = ~(state == S_P_STROBE || (state == S_STROBE && op_q[1]));
  assign n_wr        = ~(state == S_STROBE && is_write);
  assign n_m1        = 1'b1;

endmodule

// File: tb/tb_gs_host_master.sv
// Directed bench for gs_host_master: a vector table of commands with hand-computed
// responses, plus hand-written reset-mid-strobe and back-to-back sequences.
module tb_gs_host_master;

  localparam int POLL_MAX = 4;

  logic        clk32 = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_poll;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;
  logic        n_iorq;
  logic        n_rd;
  logic        n_wr;
  logic        n_m1;

  gs_host_master #(.POLL_MAX(POLL_MAX)) dut (
    .clk32       (clk32),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_poll    (cmd_poll),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .a           (a),
    .d_out       (d_out),
    .d_oe        (d_oe),
    .d_in        (d_in),
    .n_iorq      (n_iorq),
    .n_rd        (n_rd),
    .n_wr        (n_wr),
    .n_m1        (n_m1)
  );

  always #5 clk32 = ~clk32;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // GS responder: status bytes for #BB reads come from a per-command script.
  logic [7:0]       din_val = 8'h00;
  logic [3:0][7:0]  cur_st  = '0;
  int               rd_bb_cnt = 0;
  int               st_base   = 0;
  logic [1:0]       st_sel;

  always @(posedge n_rd) if (a[7:0] == 8'hBB) rd_bb_cnt++;

  always_comb begin
    st_sel = 2'd3;
    if (rd_bb_cnt - st_base < 3) st_sel = 2'(rd_bb_cnt - st_base);
  end
  assign d_in = (a[7:0] == 8'hBB) ? cur_st[st_sel] : din_val;

  // Bus monitor: logs each strobe and counts protocol violations.
  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic [7:0]  data;
    int          len;
  } bus_t;

  bus_t        bus_log[$];
  int          strobe_len = 0;
  logic [15:0] cur_a = '0;
  logic        cur_rd = 1'b0;
  logic [7:0]  cur_d = '0;
  logic        prev_iorq = 1'b1;
  logic        prev_doe = 1'b0;
  logic [7:0]  prev_dout = '0;
  int          doe_len = 0;
  int          last_doe_len = 0;
  int          rule_err = 0;
  int          rsp_seen = 0;

  always @(negedge clk32) begin
    if (rsp_valid) rsp_seen++;
    if (d_oe && !n_rd) rule_err++;
    if (!n_rd && !n_wr) rule_err++;
    if (!n_iorq && n_rd && n_wr) rule_err++;
    if ((!n_rd || !n_wr) && n_iorq) rule_err++;
    if (!n_m1) rule_err++;
    if (d_oe && prev_doe && d_out !== prev_dout) rule_err++;
    if (!n_iorq) begin
      if (prev_iorq) begin
        strobe_len = 0;
        cur_a  = a;
        cur_rd = !n_rd;
        cur_d  = d_out;
      end
      strobe_len++;
      if (a !== cur_a) rule_err++;
    end else if (!prev_iorq) begin
      bus_log.push_back('{cur_a, cur_rd, cur_d, strobe_len});
    end
    prev_iorq = n_iorq;
    if (d_oe) doe_len++;
    else begin
      if (doe_len > 0) last_doe_len = doe_len;
      doe_len = 0;
    end
    prev_doe  = d_oe;
    prev_dout = d_out;
  end

  typedef struct {
    logic [1:0]      op;
    logic            poll;
    logic [7:0]      wdata;
    logic [7:0]      din;
    logic [3:0][7:0] st;
    int              exp_bus;
    logic [15:0]     exp_addr;
    logic            exp_rd;
    logic [7:0]      exp_rdata;
    logic            exp_to;
    int              exp_lat;
  } vec_t;

  vec_t vecs[8];

  // Latency counts clock cycles after the accepting edge up to and including the rsp_valid cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int   lat;
    int   base;
    int   bad_len;
    int   bad_poll;
    bus_t last;
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk32);
    cur_st   = v.st;
    st_base  = rd_bb_cnt;
    din_val  = v.din;
    base     = bus_log.size();
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_poll  = v.poll;
    cmd_wdata = v.wdata;
    check({p, "_ready"}, cmd_ready, 1'b1);
    @(negedge clk32);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 300) begin
      @(negedge clk32);
      lat++;
    end
    check({p, "_latency"}, lat, v.exp_lat);
    check({p, "_rdata"}, rsp_rdata, v.exp_rdata);
    check({p, "_timeout"}, rsp_timeout, v.exp_to);
    check({p, "_bus_cycles"}, bus_log.size() - base, v.exp_bus);
    last = '{16'h0, 1'b0, 8'h0, 0};
    if (bus_log.size() > base) last = bus_log[bus_log.size() - 1];
    check({p, "_addr"}, last.addr, v.exp_addr);
    check({p, "_dir_rd"}, last.rd, v.exp_rd);
    bad_len  = 0;
    bad_poll = 0;
    for (int i = base; i < bus_log.size(); i++) begin
      if (bus_log[i].len != 6) bad_len++;
      if (i < bus_log.size() - 1 && (bus_log[i].addr !== 16'h00BB || !bus_log[i].rd)) bad_poll++;
    end
    check({p, "_strobe_len_bad"}, bad_len, 0);
    check({p, "_poll_reads_bad"}, bad_poll, 0);
    if (!v.exp_rd) check({p, "_wdata"}, last.data, v.wdata);
    @(negedge clk32);
    check({p, "_idle_ready"}, {cmd_ready, rsp_valid, n_iorq, d_oe}, 4'b1010);
    check({p, "_addr_hold"}, a, v.exp_addr);
    if (!v.exp_rd) check({p, "_doe_cycles"}, last_doe_len, 10);
  endtask

  logic [1:0] b2b_ops [3] = '{2'd0, 2'd1, 2'd3};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_poll  = 1'b0;
    cmd_wdata = 8'h00;

    //          op    poll  wdata  din    status script (last byte read first)  bus  addr      rd    rdata  to    lat
    vecs[0] = '{2'd1, 1'b0, 8'h5A, 8'h00, 32'h0000_0000,                        1,   16'h00BB, 1'b0, 8'h00, 1'b0, 11};
    vecs[1] = '{2'd2, 1'b0, 8'h00, 8'hC3, 32'h0000_0000,                        1,   16'h00B3, 1'b1, 8'hC3, 1'b0, 11};
    vecs[2] = '{2'd1, 1'b1, 8'h3C, 8'h00, 32'h0000_0101,                        4,   16'h00BB, 1'b0, 8'hC3, 1'b0, 44};
    vecs[3] = '{2'd2, 1'b1, 8'h00, 8'h55, 32'h7F7F_7F7F,                        4,   16'h00BB, 1'b1, 8'h7F, 1'b1, 45};
    vecs[4] = '{2'd0, 1'b0, 8'hA5, 8'h00, 32'h0000_0000,                        1,   16'h00B3, 1'b0, 8'h7F, 1'b0, 11};
    vecs[5] = '{2'd3, 1'b1, 8'h00, 8'h00, 32'h8181_8181,                        1,   16'h00BB, 1'b1, 8'h81, 1'b0, 11};
    vecs[6] = '{2'd0, 1'b1, 8'h77, 8'h00, 32'h0000_0080,                        3,   16'h00B3, 1'b0, 8'h81, 1'b0, 33};
    vecs[7] = '{2'd2, 1'b1, 8'h00, 8'h99, 32'h8080_8000,                        3,   16'h00B3, 1'b1, 8'h99, 1'b0, 33};

    repeat (3) @(negedge clk32);
    check("rst_addr", a, 16'h0000);
    check("rst_dout", {d_out, d_oe}, 9'h000);
    check("rst_strobes", {n_iorq, n_rd, n_wr, n_m1}, 4'hF);
    check("rst_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, 10'h000);
    rst = 1'b0;
    @(negedge clk32);
    check("rst_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Back-to-back: cmd_valid stays high while three ops are fed as each is accepted.
    begin
      int   k = 0;
      int   rsp_n = 0;
      int   gap_err = 0;
      int   base;
      logic prev_rsp = 1'b0;
      base     = bus_log.size();
      cmd_poll = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk32);
        if (prev_rsp && !cmd_ready) gap_err++;
        if (rsp_valid) rsp_n++;
        prev_rsp = rsp_valid;
        if (cmd_ready) begin
          if (k < 3) begin
            cmd_op    = b2b_ops[k];
            cmd_wdata = 8'h10 + 8'(k);
            cmd_valid = 1'b1;
            k++;
          end else begin
            cmd_valid = 1'b0;
          end
        end
        if (k == 3 && rsp_n == 3 && !cmd_valid) break;
      end
      cmd_valid = 1'b0;
      check("b2b_responses", rsp_n, 3);
      check("b2b_bus_cycles", bus_log.size() - base, 3);
      check("b2b_idle_gap_err", gap_err, 0);
      if (bus_log.size() - base == 3) begin
        check("b2b_addr0", {bus_log[base].addr, bus_log[base].rd}, {16'h00B3, 1'b0});
        check("b2b_addr1", {bus_log[base+1].addr, bus_log[base+1].rd}, {16'h00BB, 1'b0});
        check("b2b_addr2", {bus_log[base+2].addr, bus_log[base+2].rd}, {16'h00BB, 1'b1});
      end
    end

    // Reset mid-strobe of a write: strobes and d_oe must drop before the next clock edge.
    begin
      int w = 0;
      int rsp_before;
      @(negedge clk32);
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      cmd_poll  = 1'b0;
      cmd_wdata = 8'hE1;
      @(negedge clk32);
      cmd_valid = 1'b0;
      while (n_wr && w < 20) begin
        @(negedge clk32);
        w++;
      end
      check("mid_rst_reached_strobe", n_wr, 1'b0);
      @(negedge clk32);
      rsp_before = rsp_seen;
      #2 rst = 1'b1;
      #1;
      check("mid_rst_strobes", {n_iorq, n_wr, n_rd}, 3'b111);
      check("mid_rst_doe", d_oe, 1'b0);
      check("mid_rst_rsp", rsp_valid, 1'b0);
      repeat (3) @(negedge clk32);
      rst = 1'b0;
      @(negedge clk32);
      check("mid_rst_ready", cmd_ready, 1'b1);
      repeat (15) @(negedge clk32);
      check("mid_rst_no_rsp", rsp_seen - rsp_before, 0);
      check("mid_rst_bus_idle", {n_iorq, d_oe}, 2'b10);
    end

    check("protocol_rule_err", rule_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
